// File: rtl/msg_encrypt_engine_pkg.sv
// Shared constants, FSM encodings and the legal tap table for the LFSR message encryptor.
// The tap table is consulted only when ENC_TAP_CHECK_EN is defined.
package msg_encrypt_engine_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CFG0 = 3'd1;
  localparam state_t ST_CFG1 = 3'd2;
  localparam state_t ST_CFG2 = 3'd3;
  localparam state_t ST_RD   = 3'd4;
  localparam state_t ST_WR   = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam logic [7:0] CFG_BASE = 8'd61;
  localparam logic [7:0] OUT_BASE = 8'd64;
  localparam logic [6:0] MSG_MAX  = 7'd52;
  localparam logic [6:0] OUT_LEN  = 7'd64;
  localparam logic [5:0] LAST_IDX = 6'(OUT_LEN - 7'd1);
  localparam logic [3:0] PRE_MIN  = 4'd10;
  localparam logic [3:0] PRE_MAX  = 4'd15;
  localparam logic [7:0] SPACE    = 8'h20;

  localparam logic [6:0] LFSR_PTRN [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                           7'h69, 7'h5C, 7'h7E, 7'h7B};

  function automatic logic tap_legal(input logic [6:0] t);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (LFSR_PTRN[i] == t) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/msg_encrypt_engine_if.sv
// Start/done handshake plus the data-memory port of the encryptor.
// req/ack: a high-then-low req launches a run; ack stays high in DONE until req rises again.
interface msg_encrypt_engine_if;
  logic       req;
  logic       ack;
  logic       err;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;

  modport master (
    input  req, dm_rd_data,
    output ack, err, dm_addr, dm_wr_en, dm_wr_data
  );

  modport slave (
    output req, dm_rd_data,
    input  ack, err, dm_addr, dm_wr_en, dm_wr_data
  );
endinterface

// File: rtl/msg_encrypt_engine_lfsr7_step.sv
// One step of the 7-bit Fibonacci LFSR: shift left, feedback is parity of state&taps.
// Kept standalone so the decrypt accelerator can reuse it.
module lfsr7_step (
  input  logic [6:0] state,
  input  logic [6:0] taps,
  output logic [6:0] next_state
);
  assign next_state = {state[5:0], ^(state & taps)};
endmodule

// File: rtl/msg_encrypt_engine.sv
// LFSR encryptor: reads message DM[0..51] and config DM[61..63], writes 64 parity-tagged bytes to DM[64..127].
// Optional tap legality check enabled by defining ENC_TAP_CHECK_EN.
module msg_encrypt_engine
  import msg_encrypt_engine_pkg::*;
(
  input  logic                       clk,
  input  logic                       init_n,
  msg_encrypt_engine_if.master       bus,
  output logic [2:0]                 state_dbg
);

  state_t     state;
  logic       armed;
  logic [5:0] idx;
  logic [3:0] pre;
  logic [6:0] taps;
  logic [6:0] lfsr;
  logic [6:0] lfsr_next;
  logic [7:0] addr_q;
  logic [7:0] wr_data_q;
  logic       wr_en_q;
  logic       ack_q;
  logic [7:0] rd;
  logic [6:0] p;
  logic [6:0] c;
  logic [5:0] idx_inc;

  assign rd      = bus.dm_rd_data;
  assign idx_inc = idx + 6'd1;

  lfsr7_step u_step (
    .state      (lfsr),
    .taps       (taps),
    .next_state (lfsr_next)
  );

  function automatic logic msg_hit(input logic [5:0] i, input logic [3:0] pr);
    logic [6:0] off;
    off = {1'b0, i} - {3'b0, pr};
    return (i >= {2'b0, pr}) && (off < MSG_MAX);
  endfunction

  function automatic logic [7:0] msg_addr(input logic [5:0] i, input logic [3:0] pr);
    logic [6:0] off;
    off = {1'b0, i} - {3'b0, pr};
    return {1'b0, off};
  endfunction

  // Only 7 bits of plaintext enter the XOR, so mod-128 subtraction gives the same bits as mod-256.
  always_comb begin
    p = 7'h00;
    if (msg_hit(idx, pre)) p = rd[6:0] - SPACE[6:0];
    c = p ^ lfsr;
  end

`ifdef ENC_TAP_CHECK_EN
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      idx       <= 6'd0;
      pre       <= PRE_MIN;
      taps      <= 7'h00;
      lfsr      <= 7'h01;
      addr_q    <= 8'h00;
      wr_data_q <= 8'h00;
      wr_en_q   <= 1'b0;
      ack_q     <= 1'b0;
`ifdef ENC_TAP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      armed   <= bus.req;
      wr_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && !bus.req) begin
            state  <= ST_CFG0;
            idx    <= 6'd0;
            addr_q <= CFG_BASE;
          end
        end
        ST_CFG0: begin
          if (rd < {4'h0, PRE_MIN})      pre <= PRE_MIN;
          else if (rd > {4'h0, PRE_MAX}) pre <= PRE_MAX;
          else                           pre <= rd[3:0];
          addr_q <= CFG_BASE + 8'd1;
          state  <= ST_CFG1;
        end
        ST_CFG1: begin
          taps   <= rd[6:0];
          addr_q <= CFG_BASE + 8'd2;
          state  <= ST_CFG2;
        end
        ST_CFG2: begin
`ifdef ENC_TAP_CHECK_EN
          if (!tap_legal(taps)) begin
            state <= ST_DONE;
            ack_q <= 1'b1;
            err_q <= 1'b1;
          end else begin
            lfsr  <= (rd[6:0] == 7'h00) ? 7'h01 : rd[6:0];
            state <= ST_RD;
          end
`else
          lfsr  <= (rd[6:0] == 7'h00) ? 7'h01 : rd[6:0];
          state <= ST_RD;
`endif
        end
        ST_RD: begin
          wr_en_q   <= 1'b1;
          wr_data_q <= {^c, c};
          addr_q    <= OUT_BASE + {2'b0, idx};
          state     <= ST_WR;
        end
        ST_WR: begin
          lfsr <= lfsr_next;
          idx  <= idx_inc;
          if (idx < LAST_IDX) begin
            state <= ST_RD;
            // Padding positions keep the last address; the read value is ignored there.
            if (msg_hit(idx_inc, pre)) addr_q <= msg_addr(idx_inc, pre);
          end else begin
            state <= ST_DONE;
            ack_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.req && !armed) begin
            state <= ST_IDLE;
            ack_q <= 1'b0;
`ifdef ENC_TAP_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.dm_addr    = addr_q;
  assign bus.dm_wr_en   = wr_en_q;
  assign bus.dm_wr_data = wr_data_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_msg_encrypt_engine.sv
// Directed bench for msg_encrypt_engine: memory model, reference keystream model, scoreboard queue.
// Covers config clamping, zero-seed fix-up, mid-run reset, req during run and ENC_TAP_CHECK_EN.
module tb_msg_encrypt_engine;

  logic       clk;
  logic       init_n;
  logic [2:0] state_dbg;
  logic [7:0] src [64];
  logic [7:0] out_mem [64];
  int         wr_cnt;
  int         stray_cnt;
  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q [$];

  msg_encrypt_engine_if bus ();

  msg_encrypt_engine dut (
    .clk       (clk),
    .init_n    (init_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge
  assign bus.dm_rd_data = (bus.dm_addr < 8'd64) ? src[bus.dm_addr[5:0]] : out_mem[bus.dm_addr[5:0]];

  always @(posedge clk) begin
    if (bus.dm_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.dm_addr >= 8'd64 && bus.dm_addr <= 8'd127) out_mem[bus.dm_addr[5:0]] <= bus.dm_wr_data;
      else stray_cnt <= stray_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic load_cfg(input string s, input logic [7:0] pre, input logic [7:0] taps,
                          input logic [7:0] init);
    for (int i = 0; i < 64; i++) src[i] = 8'h00;
    for (int i = 0; i < 52; i++) src[i] = (i < s.len()) ? s[i] : 8'h20;
    src[61] = pre;
    src[62] = taps;
    src[63] = init;
  endtask

  task automatic start_run();
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int start_edges, input int exp_edges);
    int edges;
    edges = start_edges;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.ack) break;
    end
    check(tag, edges, exp_edges);
  endtask

  // Reference model: builds the expected 64-byte image from the source memory
  task automatic build_exp(input logic [7:0] pre_raw, input logic [7:0] taps_raw,
                           input logic [7:0] init_raw);
    int         pre;
    logic [6:0] l;
    logic [6:0] t;
    logic [7:0] p;
    logic [6:0] c;
    logic       fb;
    pre = (pre_raw < 8'd10) ? 10 : (pre_raw > 8'd15) ? 15 : int'(pre_raw);
    l   = (init_raw[6:0] == 7'h00) ? 7'h01 : init_raw[6:0];
    t   = taps_raw[6:0];
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = 8'h00;
      if (i - pre >= 0 && i - pre < 52) p = src[i - pre] - 8'h20;
      c = p[6:0] ^ l;
      exp_q.push_back({^c, c});
      fb = 1'b0;
      for (int b = 0; b < 7; b++) fb = fb ^ (l[b] & t[b]);
      l = {l[5:0], fb};
    end
  endtask

  task automatic check_image(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, " queue empty"}, 32'd1, 32'd0);
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("%s byte %0d", tag, i), {24'h0, out_mem[i]}, {24'h0, e});
    end
  endtask

  task automatic full_run(input string tag, input string msg, input logic [7:0] pre,
                          input logic [7:0] taps, input logic [7:0] init);
    int base;
    load_cfg(msg, pre, taps, init);
    build_exp(pre, taps, init);
    base = wr_cnt;
    start_run();
    wait_ack({tag, " latency"}, 0, 132);
    check({tag, " writes"}, wr_cnt - base, 64);
    check({tag, " err"}, {31'h0, bus.err}, 0);
    check_image(tag);
  endtask

  initial begin
    int base;
    n_tests   = 0;
    n_fail    = 0;
    wr_cnt    = 0;
    stray_cnt = 0;
    for (int i = 0; i < 64; i++) out_mem[i] = 8'hEE;
    init_n  = 1'b0;
    bus.req = 1'b0;
    #12;
    check("reset ack", {31'h0, bus.ack}, 0);
    check("reset err", {31'h0, bus.err}, 0);
    check("reset wr_en", {31'h0, bus.dm_wr_en}, 0);
    check("reset addr", {24'h0, bus.dm_addr}, 0);
    check("reset wr_data", {24'h0, bus.dm_wr_data}, 0);
    check("reset state", {29'h0, state_dbg}, 0);
    @(negedge clk);
    init_n = 1'b1;

    // 1: reference message
    full_run("t1", "Mr. Watson, come here. I want to see you.", 8'd10, 8'h6A, 8'h39);
    check("t1 dm64", {24'h0, out_mem[0]}, 32'h39);
    check("t1 dm65", {24'h0, out_mem[1]}, 32'h72);

    // 2: zero seed becomes 01
    full_run("t2", "Zero seed", 8'd10, 8'h60, 8'h00);
    check("t2 dm64", {24'h0, out_mem[0]}, 32'h81);
    check("t2 dm65", {24'h0, out_mem[1]}, 32'h82);

    // 3: pre clamping, plus a high-bit message byte
    load_cfg("HELLO", 8'd5, 8'h48, 8'h5A);
    full_run("t3a", "HELLO\xC1!", 8'd5, 8'h48, 8'h5A);
    full_run("t3b", "Fifteen pad", 8'd15, 8'h78, 8'h2B);
    full_run("t3c", "Big pre", 8'd200, 8'h7B, 8'h7F);

    // 4: reset while the write strobe is high
    load_cfg("Mr. Watson, come here. I want to see you.", 8'd10, 8'h6A, 8'h39);
    start_run();
    repeat (41) @(posedge clk);
    #1;
    check("t4 wr_en before reset", {31'h0, bus.dm_wr_en}, 1);
    #1;
    init_n = 1'b0;
    #1;
    check("t4 ack", {31'h0, bus.ack}, 0);
    check("t4 wr_en", {31'h0, bus.dm_wr_en}, 0);
    check("t4 state", {29'h0, state_dbg}, 0);
    check("t4 addr", {24'h0, bus.dm_addr}, 0);
    @(negedge clk);
    init_n = 1'b1;
    for (int i = 0; i < 64; i++) out_mem[i] = 8'hEE;
    full_run("t4 rerun", "Mr. Watson, come here. I want to see you.", 8'd10, 8'h6A, 8'h39);

    // 5: req pulse mid-run is ignored; req rise in DONE drops ack
    load_cfg("Pulse test", 8'd12, 8'h69, 8'h11);
    build_exp(8'd12, 8'h69, 8'h11);
    start_run();
    repeat (60) @(posedge clk);
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    wait_ack("t5 latency", 61, 132);
    check_image("t5");
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    check("t5 ack drop", {31'h0, bus.ack}, 0);
    check("t5 state idle", {29'h0, state_dbg}, 0);

    // 6: illegal taps
`ifdef ENC_TAP_CHECK_EN
    load_cfg("Bad taps", 8'd10, 8'h55, 8'h21);
    base = wr_cnt;
    start_run();
    wait_ack("t6 latency", 0, 4);
    check("t6 err", {31'h0, bus.err}, 1);
    check("t6 writes", wr_cnt - base, 0);
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    check("t6 err clear", {31'h0, bus.err}, 0);
    check("t6 ack clear", {31'h0, bus.ack}, 0);
`else
    base = 0;
    full_run("t6", "Bad taps", 8'd10, 8'h55, 8'h21);
`endif

    check("stray writes", stray_cnt + base * 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
